// File: rtl/shift_issue_stage_pkg.sv
// Shared types and helpers for the shifter issue stage.
// No logic; constants, op encoding, stored entry layout and bit-reverse.
// Backpressure: n/a.
package shift_pkg;

   localparam int WIDTH = 32;
   localparam int SHW   = 5;

   typedef enum logic [1:0] {
      SHIFT_SLL = 2'd0,
      SHIFT_SRL = 2'd1,
      SHIFT_SRA = 2'd2,
      SHIFT_ILL = 2'd3
   } shift_op_t;

   // Pre-conditioned request as seen by the right-shift stage chain.
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             fill;
      logic [SHW-1:0]   en;
      logic             rev;
      logic             err;
   } shift_entry_t;

   function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = v[WIDTH-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_issue_stage_if.sv
// Request and stage-chain handshake bundle for the shifter issue stage.
// Latency: n/a (wires only).
// Backpressure: in_ready toward master, out_ready toward slave.
interface shift_issue_if;
   import shift_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [SHW-1:0]   in_shamt;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_fill;
   logic [SHW-1:0]   out_en;
   logic             out_rev;
   logic             out_err;

   // Upstream requester that also consumes the conditioned head entry.
   modport master (
      output in_valid, in_op, in_a, in_shamt, out_ready,
      input  in_ready, out_valid, out_data, out_fill, out_en, out_rev, out_err
   );

   // The issue stage itself.
   modport slave (
      input  in_valid, in_op, in_a, in_shamt, out_ready,
      output in_ready, out_valid, out_data, out_fill, out_en, out_rev, out_err
   );
endinterface

// File: rtl/shift_issue_stage_fifo.sv
// Two-entry FIFO of a generic entry type with count and 1-bit pointers.
// Latency: pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push_ready is registered (count<DEPTH) and ignores pop_ready.
module shift_entry_fifo #(
   parameter type T     = logic [7:0],
   parameter int  DEPTH = 2
) (
   input  logic clk,
   input  logic n_rst,
   input  logic push_valid,
   output logic push_ready,
   input  T     push_data,
   output logic pop_valid,
   input  logic pop_ready,
   output T     pop_data
);

   localparam int            CW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // Pointers are single bits, so this structure only works for DEPTH=2.
   T              mem [DEPTH];
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          wr_ptr;
   logic          rd_ptr;
   logic          ready_q;
   logic          push;
   logic          pop;

   assign push       = push_valid & ready_q;
   assign pop        = pop_valid & pop_ready;
   assign pop_valid  = (count != '0);
   assign push_ready = ready_q;
   // Head is forced to zero when empty so idle outputs are clean.
   assign pop_data   = pop_valid ? mem[rd_ptr] : '0;

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // Count, pointers and ready flag; ready is derived from next count so it
   // is a flop yet always equals count<DEPTH, and stays low during reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count   <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         count   <= count_nxt;
         ready_q <= (count_nxt < FULL);
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
      end
   end

   // Entry storage; cleared on reset so nothing stale survives.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/shift_issue_stage.sv
// Issue stage: decodes shift op, pre-conditions operand, buffers in 2-entry FIFO.
// Latency: 1 cycle from accepted request to head on out_*; 1/cycle sustained.
// Backpressure: in_ready=0 when both entries are full, independent of out_ready.
module shift_issue_stage
   import shift_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          n_rst,
   shift_issue_if.slave  bus
);

   shift_entry_t ent_in;
   shift_entry_t ent_head;
   logic         head_valid;
   logic         push_ready;

   // Conditioning happens at push time so outputs come only from stored state.
   // Left shifts are reversed so the right-shift chain can serve them.
   always_comb begin
      ent_in      = '0;
      ent_in.data = bus.in_a;
      ent_in.en   = bus.in_shamt;
      case (shift_op_t'(bus.in_op))
         SHIFT_SLL: begin
            ent_in.data = bitrev(bus.in_a);
            ent_in.rev  = 1'b1;
         end
         SHIFT_SRL: begin
            ent_in.fill = 1'b0;
         end
         SHIFT_SRA: begin
            ent_in.fill = bus.in_a[WIDTH-1];
         end
         default: begin
            // Illegal op: operand passes through unshifted and is flagged.
            ent_in.en  = '0;
            ent_in.err = 1'b1;
         end
      endcase
   end

   shift_entry_fifo #(
      .T     (shift_entry_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .n_rst      (n_rst),
      .push_valid (bus.in_valid),
      .push_ready (push_ready),
      .push_data  (ent_in),
      .pop_valid  (head_valid),
      .pop_ready  (bus.out_ready),
      .pop_data   (ent_head)
   );

   assign bus.in_ready  = push_ready;
   assign bus.out_valid = head_valid;
   assign bus.out_data  = ent_head.data;
   assign bus.out_fill  = ent_head.fill;
   assign bus.out_en    = ent_head.en;
   assign bus.out_rev   = ent_head.rev;
   assign bus.out_err   = ent_head.err;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for the shifter issue stage: scoreboard of conditioned entries.
// Expected entries are queued at accept and compared at pop.
// Downstream shift + un-reverse model checks the final shift result.
module tb_shift_issue_stage;

   logic clk = 1'b0;
   logic n_rst;

   always #5 clk = ~clk;

   shift_issue_if bus();

   shift_issue_stage #(.DEPTH(2)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] data;
      logic        fill;
      logic [4:0]  en;
      logic        rev;
      logic        err;
      logic [31:0] res;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   logic rdy_model = 1'b0;
   int   max_sz = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] rev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   // Reference: conditioned entry plus the architectural shift result.
   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [4:0] s);
      exp_t e;
      e.data = a; e.fill = 1'b0; e.en = s; e.rev = 1'b0; e.err = 1'b0; e.res = a;
      case (op)
         2'd0: begin e.data = rev32(a); e.rev = 1'b1; e.res = a << s; end
         2'd1: e.res = a >> s;
         2'd2: begin e.fill = a[31]; e.res = $unsigned($signed(a) >>> s); end
         default: begin e.en = 5'd0; e.err = 1'b1; e.res = a; end
      endcase
      return e;
   endfunction

   // Downstream stage chain: right shift with fill, then optional un-reverse.
   function automatic logic [31:0] downstream(input logic [31:0] d, input logic f,
                                              input logic [4:0] en, input logic rv);
      logic [63:0] w;
      logic [31:0] r;
      w = {{32{f}}, d} >> en;
      r = w[31:0];
      return rv ? rev32(r) : r;
   endfunction

   // Cycle monitor: handshake model, scoreboard push/pop and compare.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!n_rst) begin
            sb.delete();
            rdy_model = 1'b0;
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_in_ready", bus.in_ready, 0);
         end else begin
            check("out_valid", bus.out_valid, sb.size() != 0);
            check("in_ready", bus.in_ready, rdy_model);
            if (bus.out_valid && bus.out_ready) begin
               if (sb.size() == 0) begin
                  check("pop_without_entry", 1, 0);
               end else begin
                  e = sb.pop_front();
                  check("out_data", bus.out_data, e.data);
                  check("out_fill", bus.out_fill, e.fill);
                  check("out_en",   bus.out_en,   e.en);
                  check("out_rev",  bus.out_rev,  e.rev);
                  check("out_err",  bus.out_err,  e.err);
                  check("result", downstream(bus.out_data, bus.out_fill, bus.out_en, bus.out_rev), e.res);
               end
            end
            if (bus.in_valid && bus.in_ready)
               sb.push_back(model(bus.in_op, bus.in_a, bus.in_shamt));
            if (sb.size() > max_sz) max_sz = sb.size();
            rdy_model = (sb.size() < 2);
         end
      end
   end

   // Drive one request and hold it until accepted (bounded wait).
   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [4:0] s);
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_shamt = s;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (!ok) check("send_timeout", 0, 1);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_valid"}, bus.out_valid, 0);
      check({tag, "_data"},  bus.out_data, 0);
      check({tag, "_fill"},  bus.out_fill, 0);
      check({tag, "_en"},    bus.out_en, 0);
      check({tag, "_rev"},   bus.out_rev, 0);
      check({tag, "_err"},   bus.out_err, 0);
      check({tag, "_ready"}, bus.in_ready, 0);
   endtask

   initial begin
      time t0;
      n_rst = 1'b0;
      bus.in_valid = 1'b0; bus.in_op = 2'd0; bus.in_a = '0; bus.in_shamt = '0;
      bus.out_ready = 1'b1;
      #3;
      check_idle_zero("reset");
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;
      @(posedge clk); #1;
      check("ready_after_release", bus.in_ready, 1);

      // SRA with negative operand
      send(2'd2, 32'h8000_0010, 5'd4);
      check("sra_valid", bus.out_valid, 1);
      check("sra_data", bus.out_data, 32'h8000_0010);
      check("sra_fill", bus.out_fill, 1);
      check("sra_en",   bus.out_en, 5'b00100);
      check("sra_rev",  bus.out_rev, 0);

      // SLL reversed for the right-shift chain
      send(2'd0, 32'h0000_0001, 5'd3);
      check("sll_data", bus.out_data, 32'h8000_0000);
      check("sll_rev",  bus.out_rev, 1);
      check("sll_en",   bus.out_en, 5'd3);
      check("sll_result", downstream(bus.out_data, bus.out_fill, bus.out_en, bus.out_rev), 32'h0000_0008);

      // Illegal op, then legal entries with shamt=0
      send(2'd3, 32'hDEAD_BEEF, 5'd7);
      check("ill_data", bus.out_data, 32'hDEAD_BEEF);
      check("ill_en",   bus.out_en, 0);
      check("ill_err",  bus.out_err, 1);
      send(2'd2, 32'h8000_0001, 5'd0);
      check("after_ill_err", bus.out_err, 0);
      check("sra0_fill", bus.out_fill, 1);
      check("sra0_en",   bus.out_en, 0);
      send(2'd1, 32'hF000_0000, 5'd0);
      check("srl0_fill", bus.out_fill, 0);
      repeat (3) @(posedge clk); #1;

      // Backpressure: three back-to-back requests against a stalled sink
      bus.out_ready = 1'b0;
      fork
         begin
            send(2'd1, 32'h0000_00A0, 5'd1);
            send(2'd1, 32'h0000_00B0, 5'd2);
            send(2'd1, 32'h0000_00C0, 5'd3);
         end
         begin
            repeat (5) @(negedge clk);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_count", sb.size(), 2);
            check("bp_head_a", bus.out_data, 32'h0000_00A0);
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk); #1;
      check("bp_drained", sb.size(), 0);

      // Streaming: one accept per cycle with a free-flowing sink
      max_sz = 0;
      t0 = $time;
      for (int i = 0; i < 8; i++)
         send(2'($urandom_range(0, 2)), $urandom, 5'($urandom_range(0, 31)));
      check("stream_cycles", ($time - t0) / 10, 8);
      repeat (3) @(posedge clk); #1;
      check("stream_max_count", max_sz, 1);

      // Random ops against a randomly stalling sink
      fork
         begin
            for (int i = 0; i < 24; i++)
               send(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
         end
         begin
            for (int i = 0; i < 60; i++) begin
               @(posedge clk); #2;
               bus.out_ready = 1'($urandom_range(0, 1));
            end
            bus.out_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk); #1;
      check("rand_drained", sb.size(), 0);

      // Asynchronous reset with a full FIFO
      bus.out_ready = 1'b0;
      send(2'd0, 32'h1234_5678, 5'd9);
      send(2'd2, 32'h8765_4321, 5'd2);
      check("pre_rst_full", sb.size(), 2);
      #2 n_rst = 1'b0;
      #1;
      check_idle_zero("midrst");
      @(posedge clk); #1 n_rst = 1'b1;
      @(posedge clk); #1;
      check("post_rst_ready", bus.in_ready, 1);
      check("post_rst_valid", bus.out_valid, 0);
      bus.out_ready = 1'b1;
      send(2'd1, 32'h0000_0F00, 5'd4);
      repeat (3) @(posedge clk); #1;
      check("post_rst_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
